// File: rtl/estagio_if.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS
// pipeline. Owns the PC and a write-loadable instruction memory. Applies
// redirect/stall/flush. Registers the fetched word with PC+4 for decode.
module estagio_if #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        pc_src,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       jump_target,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_wdata,
  output logic [31:0]       pc_out,
  output logic [31:0]       instr_out,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [15:0]       address,
  output logic [25:0]       adressjump,
  output logic [31:0]       PC4ID,
  output logic              valid
);

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_src_e;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;

  logic [ADDR_W-1:0] fetch_idx;
  logic              fetch_oob;
  logic [31:0]       fetch_word;
  logic [31:0]       pc4;
  pc_src_e           sel;

  // Instruction memory write port; contents survive reset.
  // NOTE: the array has no reset branch on purpose -- clearing a RAM on reset
  // would turn it into thousands of flops instead of a memory macro.
  always_ff @(posedge clock) begin
    if (imem_we) begin
      mem_q[imem_addr] <= imem_wdata;
    end
  end

  // Combinational fetch; PCs beyond the array decode to a NOP. Since the
  // write above is registered, a same-cycle write is not yet visible here.
  assign fetch_idx  = pc_q[ADDR_W+1:2];
  assign fetch_oob  = |pc_q[31:ADDR_W+2];
  assign fetch_word = fetch_oob ? 32'h0 : mem_q[fetch_idx];
  assign pc4        = pc_q + 32'd4;
  assign sel        = pc_src_e'(pc_src);

  // Next-state selection: redirect > (flush for IF/ID) > stall > normal.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (sel == PC_BRANCH || sel == PC_JUMP) begin
      pc_d    = (sel == PC_BRANCH) ? {branch_target[31:2], 2'b00}
                                   : {jump_target[31:2], 2'b00};
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else begin
      if (!stall) begin
        pc_d = pc4;
      end
      if (flush) begin
        instr_d = 32'h0;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end else if (!stall) begin
        instr_d = fetch_word;
        pc4_d   = pc4;
        valid_d = 1'b1;
      end
    end
  end

  // PC and IF/ID register with synchronous reset taking precedence.
  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out     = pc_q;
  assign instr_out  = instr_q;
  assign PC4ID      = pc4_q;
  assign valid      = valid_q;
  assign opcode     = instr_q[31:26];
  assign rs         = instr_q[25:21];
  assign rt         = instr_q[20:16];
  assign rd         = instr_q[15:11];
  assign funct      = instr_q[5:0];
  assign address    = instr_q[15:0];
  assign adressjump = instr_q[25:0];

endmodule

// File: tb/tb_estagio_if.sv
// Directed bench for estagio_if: expected post-edge state is queued when each
// step is driven and popped/compared after the edge.
module tb_estagio_if;

  localparam int ADDR_W = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              stall;
  logic              flush;
  logic [1:0]        pc_src;
  logic [31:0]       branch_target;
  logic [31:0]       jump_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [31:0]       pc_out;
  logic [31:0]       instr_out;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [5:0]        funct;
  logic [15:0]       address;
  logic [25:0]       adressjump;
  logic [31:0]       PC4ID;
  logic              valid;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vld;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] W0 = 32'h20080005;
  localparam logic [31:0] W1 = 32'h20090003;
  localparam logic [31:0] W2 = 32'h01095020;
  localparam logic [31:0] W3 = 32'hAC0A0000;
  localparam logic [31:0] W6 = 32'h11111111;
  localparam logic [31:0] W8 = 32'h8C0B0004;

  estagio_if #(.DEPTH(256), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .pc_src(pc_src), .branch_target(branch_target), .jump_target(jump_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pc_out(pc_out), .instr_out(instr_out), .opcode(opcode), .rs(rs),
    .rt(rt), .rd(rd), .funct(funct), .address(address),
    .adressjump(adressjump), .PC4ID(PC4ID), .valid(valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
    branch_target = 32'h0; jump_target = 32'h0;
    imem_we = 1'b0; imem_addr = '0; imem_wdata = 32'h0;
  endtask

  // Queue the expected post-edge state, clock once, then pop and compare.
  task automatic step(input string tag, input logic [31:0] e_pc,
                      input logic [31:0] e_instr, input logic [31:0] e_pc4,
                      input logic e_vld);
    exp_t e;
    sb_q.push_back('{tag, e_pc, e_instr, e_pc4, e_vld});
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".pc"},    pc_out,    e.pc);
    check({e.tag, ".instr"}, instr_out, e.instr);
    check({e.tag, ".pc4"},   PC4ID,     e.pc4);
    check({e.tag, ".valid"}, {31'h0, valid}, {31'h0, e.vld});
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_addr = a; imem_wdata = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1'b1;
    #1;
    // Test 1: preload under reset, then sequential fetch.
    preload(8'd0, W0);
    preload(8'd1, W1);
    preload(8'd2, W2);
    preload(8'd3, W3);
    preload(8'd6, W6);
    preload(8'd8, W8);
    imem_we = 1'b0;
    step("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    idle();
    step("seq0", 32'h4, W0, 32'h4, 1'b1);
    pc_src = 2'b11;  // reserved encoding behaves like PC+4
    step("seq1", 32'h8, W1, 32'h8, 1'b1);
    idle();

    // Test 2: stall two cycles at pc = 8.
    stall = 1'b1;
    step("stall0", 32'h8, W1, 32'h8, 1'b1);
    step("stall1", 32'h8, W1, 32'h8, 1'b1);
    idle();
    step("seq2", 32'hC, W2, 32'hC, 1'b1);
    check("rs", {27'h0, rs}, 32'd8);
    check("rt", {27'h0, rt}, 32'd9);
    check("rd", {27'h0, rd}, 32'd10);
    check("funct", {26'h0, funct}, 32'h20);
    check("opcode", {26'h0, opcode}, 32'h0);
    check("address", {16'h0, address}, 32'h5020);
    check("adressjump", {6'h0, adressjump}, 32'h1095020);
    step("seq3", 32'h10, W3, 32'h10, 1'b1);

    // Test 3: branch wins over stall.
    pc_src = 2'b01; branch_target = 32'h20; stall = 1'b1;
    step("branch", 32'h20, 32'h0, 32'h0, 1'b0);
    idle();
    step("branch_next", 32'h24, W8, 32'h24, 1'b1);

    // Test 4: jump with misaligned target into out-of-range space.
    pc_src = 2'b10; jump_target = 32'h403;
    step("jump", 32'h400, 32'h0, 32'h0, 1'b0);
    idle();
    step("jump_oob", 32'h404, 32'h0, 32'h404, 1'b1);

    // Test 5: flush alone at pc = 4, then flush with stall.
    pc_src = 2'b10; jump_target = 32'h4;
    step("jump4", 32'h4, 32'h0, 32'h0, 1'b0);
    idle();
    flush = 1'b1;
    step("flush", 32'h8, 32'h0, 32'h0, 1'b0);
    idle();
    step("flush_next", 32'hC, W2, 32'hC, 1'b1);
    flush = 1'b1; stall = 1'b1;
    step("flush_stall", 32'hC, 32'h0, 32'h0, 1'b0);
    idle();
    step("flush_stall_next", 32'h10, W3, 32'h10, 1'b1);

    // Test 6: reset mid-run with stall and a memory write.
    reset = 1'b1; stall = 1'b1;
    imem_we = 1'b1; imem_addr = 8'd5; imem_wdata = 32'hDEADBEEF;
    step("reset_mid", 32'h0, 32'h0, 32'h0, 1'b0);
    idle();
    pc_src = 2'b10; jump_target = 32'h14;
    step("jump5", 32'h14, 32'h0, 32'h0, 1'b0);
    idle();
    step("fetch5", 32'h18, 32'hDEADBEEF, 32'h18, 1'b1);

    // Read-before-write on the word being fetched.
    imem_we = 1'b1; imem_addr = 8'd6; imem_wdata = 32'h22222222;
    step("rbw_old", 32'h1C, W6, 32'h1C, 1'b1);
    idle();
    pc_src = 2'b10; jump_target = 32'h18;
    step("jump6", 32'h18, 32'h0, 32'h0, 1'b0);
    idle();
    step("rbw_new", 32'h1C, 32'h22222222, 32'h1C, 1'b1);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/estagio_if.md
Name: estagio_if

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline. It sits directly upstream of the decode stage. It holds the PC and owns the instruction memory, which is written through a load port. It applies stall, flush and branch/jump redirects, and registers the fetched word together with PC+4. The registered fields drive decode inputs rs, rt, rd, funct, address, adressjump and PC4ID.

Parameters:
DEPTH, 256, instruction memory depth in 32-bit words
ADDR_W, 8, width of the word index into instruction memory (log2 DEPTH)
RESET_PC, 32'h00000000, PC value loaded on reset; must be word-aligned

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hazard-unit stall: hold PC and IF/ID
flush  input  1  load a NOP bubble into IF/ID
pc_src  input  2  next-PC select: 00 = PC+4, 01 = branch_target, 10 = jump_target, 11 = reserved (acts as 00)
branch_target  input  32  branch target address
jump_target  input  32  jump target address
imem_we  input  1  instruction-memory write enable
imem_addr  input  ADDR_W  word index for writes
imem_wdata  input  32  write data
pc_out  output  32  current PC register value
instr_out  output  32  IF/ID instruction
opcode  output  6  instr_out[31:26]
rs  output  5  instr_out[25:21]
rt  output  5  instr_out[20:16]
rd  output  5  instr_out[15:11]
funct  output  6  instr_out[5:0]
address  output  16  instr_out[15:0]
adressjump  output  26  instr_out[25:0]
PC4ID  output  32  IF/ID copy of PC+4
valid  output  1  IF/ID holds a real instruction (not a bubble)

Behaviour:
- Reset is synchronous, active-high, sampled on the rising edge of clock. It overrides all other inputs.
  - On reset: pc_out = RESET_PC, instr_out = 0, PC4ID = 0, valid = 0.
  - Instruction-memory contents are not cleared by reset. Writes during reset still occur.
- Fetch path:
  - Word index = pc[ADDR_W+1:2]. The read is combinational from the memory array.
  - If pc[31:ADDR_W+2] is nonzero (out of range), the fetched word is 32'h0 (NOP).
  - pc4 = pc + 4. Addition is modulo 2^32 and wraps silently.
- Redirect (pc_src = 01 or 10) at a non-reset edge:
  - pc <= selected target with bits [1:0] forced to 0.
  - IF/ID loads a bubble: instr_out = 0, PC4ID = 0, valid = 0.
  - Redirect wins over stall when both are asserted.
- Stall (no redirect, no reset): pc and all IF/ID outputs hold their values.
- Flush (no redirect, no reset):
  - IF/ID loads a bubble.
  - pc advances to pc4 unless stall is also asserted; with stall, pc holds.
  - Flush takes priority over stall for the IF/ID register only.
- Normal edge (no redirect, stall or flush): pc <= pc4; instr_out <= fetched word; PC4ID <= pc4; valid <= 1.
- Latency: the word at address P appears on instr_out/valid one edge after pc_out == P and is not stalled.
- Field outputs (opcode, rs, rt, rd, funct, address, adressjump) are pure combinational slices of instr_out.
- Memory write: on the rising edge with imem_we = 1, mem[imem_addr] <= imem_wdata.
  - Read-before-write: a fetch from the same index in that cycle returns the old word.
  - The new word is seen from the next cycle.
- Memory contents are undefined until written. The bench preloads memory via the write port while reset is held.

Test Plan:
1. Preload words 0..3 = 32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000 under reset, then release reset. Following edges give instr_out = those words in order, PC4ID = 4, 8, 12, 16, valid = 1. For word 2: rs = 8, rt = 9, rd = 10, funct = 6'h20.
2. stall held for 2 cycles while pc_out = 8. pc_out stays 8, instr_out stays 32'h20090003, PC4ID stays 8. After release, instr_out = 32'h01095020 on the next edge.
3. pc_src = 01 with branch_target = 32'h20 and stall = 1 on the same edge. pc_out = 32'h20, instr_out = 0, valid = 0. The next edge gives instr_out = mem[8] and PC4ID = 32'h24.
4. pc_src = 10 with jump_target = 32'h403, DEPTH = 256. pc_out = 32'h400 and a bubble is loaded. The next edge gives instr_out = 0, valid = 1, PC4ID = 32'h404.
5. flush = 1 alone at pc = 4. instr_out = 0, valid = 0, pc_out = 8. The next edge gives instr_out = mem[2].
6. reset asserted mid-run with stall = 1 and imem_we = 1 writing index 5 = 32'hDEADBEEF. pc_out = 0, valid = 0, PC4ID = 0. After reset, fetching word 5 returns 32'hDEADBEEF.
